// File: rtl/airlock_ctrl.sv
// Two-door airlock sequencer: arbitrates side requests, drives pressurize/vent commands and
// interlocks the doors. Define AIRLOCK_TIMEOUT_EN to fault on a stalled pressure transition.
module airlock_ctrl #(
  parameter int unsigned DOOR_HOLD = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_outer_i,
  input  logic req_inner_i,
  input  logic pressurized_i,
  input  logic pass_done_i,
  output logic countdown_o,
  output logic vent_o,
  output logic outer_open_o,
  output logic inner_open_o,
  output logic busy_o,
  output logic fault_o
);

  localparam int unsigned MaxCnt = (DOOR_HOLD > TIMEOUT) ? DOOR_HOLD : TIMEOUT;
  localparam int unsigned TimerW = $clog2(MaxCnt + 1);
  localparam logic [TimerW-1:0] HoldLast = TimerW'(DOOR_HOLD - 1);
  localparam logic [TimerW-1:0] TimerMax = '1;
`ifdef AIRLOCK_TIMEOUT_EN
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    StIdleOut,
    StOpenOut,
    StPress,
    StIdleIn,
    StOpenIn,
    StVent,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic              loaded_q, loaded_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              count_en;
  logic              hold_met;

  assign hold_met = pass_done_i && (timer_q >= HoldLast);

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    count_en = 1'b0;
    unique case (state_q)
      StIdleOut: begin
        if (req_outer_i) begin
          state_d = StOpenOut;
        end else if (req_inner_i) begin
          state_d = StPress;
        end
      end
      StIdleIn: begin
        if (req_inner_i) begin
          state_d = StOpenIn;
        end else if (req_outer_i) begin
          state_d = StVent;
        end
      end
      StOpenOut: begin
        count_en = 1'b1;
        if (hold_met) begin
          // An empty chamber has just been boarded; a loaded one has just been emptied.
          loaded_d = ~loaded_q;
          state_d  = loaded_q ? StIdleOut : StPress;
        end
      end
      StOpenIn: begin
        count_en = 1'b1;
        if (hold_met) begin
          loaded_d = ~loaded_q;
          state_d  = loaded_q ? StIdleIn : StVent;
        end
      end
      StPress: begin
        if (pressurized_i) begin
          state_d = StOpenIn;
        end
`ifdef AIRLOCK_TIMEOUT_EN
        else if (timer_q == TimeoutLast) begin
          state_d = StFault;
        end
        count_en = 1'b1;
`endif
      end
      StVent: begin
        if (!pressurized_i) begin
          state_d = StOpenOut;
        end
`ifdef AIRLOCK_TIMEOUT_EN
        else if (timer_q == TimeoutLast) begin
          state_d = StFault;
        end
        count_en = 1'b1;
`endif
      end
      StFault: state_d = StFault;
      default: state_d = StIdleOut;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (count_en && (timer_q != TimerMax)) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdleOut;
      loaded_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      timer_q  <= timer_d;
    end
  end

  assign countdown_o  = (state_q == StPress);
  assign vent_o       = (state_q == StVent);
  assign outer_open_o = (state_q == StOpenOut);
  assign inner_open_o = (state_q == StOpenIn);
  assign busy_o       = (state_q != StIdleOut) && (state_q != StIdleIn);
`ifdef AIRLOCK_TIMEOUT_EN
  assign fault_o      = (state_q == StFault);
`else
  assign fault_o      = 1'b0;
`endif

endmodule

// File: tb/tb_airlock_ctrl.sv
// Scoreboard bench for airlock_ctrl: expected output vectors are queued with the stimulus
// and popped each cycle; a pressure model follows the commands with a 5-cycle delay.
module tb_airlock_ctrl;

  typedef logic [5:0] out_t;  // {countdown, vent, outer_open, inner_open, busy, fault}

  localparam out_t OIdle  = 6'b000000;
  localparam out_t OOut   = 6'b001010;
  localparam out_t OPress = 6'b100010;
  localparam out_t OIn    = 6'b000110;
  localparam out_t OVent  = 6'b010010;
  localparam out_t OFault = 6'b000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_outer = 1'b0;
  logic req_inner = 1'b0;
  logic pressurized = 1'b0;
  logic pass_done = 1'b0;
  logic countdown, vent, outer_open, inner_open, busy, fault;
  out_t obs;

  int checks = 0;
  int errors = 0;
  int pcnt = 0;
  bit stuck = 1'b0;
  out_t exp_q[$];

  assign obs = {countdown, vent, outer_open, inner_open, busy, fault};

  always #5 clk = ~clk;

  airlock_ctrl #(
    .DOOR_HOLD(4),
    .TIMEOUT  (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_outer_i  (req_outer),
    .req_inner_i  (req_inner),
    .pressurized_i(pressurized),
    .pass_done_i  (pass_done),
    .countdown_o  (countdown),
    .vent_o       (vent),
    .outer_open_o (outer_open),
    .inner_open_o (inner_open),
    .busy_o       (busy),
    .fault_o      (fault)
  );

  // Pressure unit model plus per-cycle interlock checks.
  always @(negedge clk) begin
    checks++;
    if ((outer_open && inner_open) || ((outer_open || inner_open) && (countdown || vent)) ||
        (countdown && vent)) begin
      errors++;
      $display("FAIL invariant: got %b required no door open with another door or command", obs);
    end
    if (rst) begin
      pcnt = 0;
      pressurized = 1'b0;
    end else if (countdown && !stuck) begin
      pcnt++;
      if (pcnt >= 5) pressurized = 1'b1;
    end else if (vent) begin
      pcnt++;
      if (pcnt >= 5) pressurized = 1'b0;
    end else begin
      pcnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic test_reset();
    out_t e;
    for (int i = 0; i < 4; i++) exp_q.push_back(OIdle);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %b required %b", i, obs, e);
      end
      if (i == 1) rst = 1'b0;
    end
  endtask

  task automatic test_outer_transfer();
    out_t e;
    for (int i = 0; i < 4; i++) exp_q.push_back(OOut);
    for (int i = 0; i < 5; i++) exp_q.push_back(OPress);
    for (int i = 0; i < 4; i++) exp_q.push_back(OIn);
    for (int i = 0; i < 2; i++) exp_q.push_back(OIdle);
    req_outer = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL outer_transfer[%0d]: got %b required %b", i, obs, e);
      end
      if (i == 0) begin
        req_outer = 1'b0;
        pass_done = 1'b1;
      end
    end
    pass_done = 1'b0;
  endtask

  task automatic test_same_side();
    out_t e;
    for (int i = 0; i < 6; i++) exp_q.push_back(OIn);
    for (int i = 0; i < 5; i++) exp_q.push_back(OVent);
    for (int i = 0; i < 4; i++) exp_q.push_back(OOut);
    exp_q.push_back(OIdle);
    req_outer = 1'b1;
    req_inner = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL same_side[%0d]: got %b required %b", i, obs, e);
      end
      if (i == 0) begin
        req_outer = 1'b0;
        req_inner = 1'b0;
      end
      if (i == 1) pass_done = 1'b1;  // early pulse, must be ignored
      if (i == 2) pass_done = 1'b0;
      if (i == 5) pass_done = 1'b1;
    end
    pass_done = 1'b0;
  endtask

  task automatic test_inner_empty();
    out_t e;
    for (int i = 0; i < 5; i++) exp_q.push_back(OPress);
    for (int i = 0; i < 4; i++) exp_q.push_back(OIn);
    for (int i = 0; i < 5; i++) exp_q.push_back(OVent);
    for (int i = 0; i < 4; i++) exp_q.push_back(OOut);
    exp_q.push_back(OIdle);
    req_inner = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL inner_empty[%0d]: got %b required %b", i, obs, e);
      end
      if (i == 0) req_inner = 1'b0;
      if (i == 5) pass_done = 1'b1;
    end
    pass_done = 1'b0;
  endtask

  task automatic test_timeout();
    out_t e;
    int n;
`ifdef AIRLOCK_TIMEOUT_EN
    n = 22;
    for (int i = 0; i < 16; i++) exp_q.push_back(OPress);
    for (int i = 16; i < n; i++) exp_q.push_back(OFault);
`else
    n = 101;
    for (int i = 0; i < n; i++) exp_q.push_back(OPress);
`endif
    stuck = 1'b1;
    req_inner = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout[%0d]: got %b required %b", i, obs, e);
      end
      if (i == 0) req_inner = 1'b0;
      if (i == 17) req_outer = 1'b1;
      if (i == 19) req_outer = 1'b0;
    end
    rst = 1'b1;
    #1;
    exp_q.push_back(OIdle);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL timeout_reset: got %b required %b", obs, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_t e;
    // Reset during PRESS.
    for (int i = 0; i < 3; i++) exp_q.push_back(OPress);
    exp_q.push_back(OIdle);
    exp_q.push_back(OIdle);
    req_inner = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_press[%0d]: got %b required %b", i, obs, e);
      end
      if (i == 0) req_inner = 1'b0;
    end
    rst = 1'b1;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_press_async: got %b required %b", obs, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_press_idle: got %b required %b", obs, e);
    end

    // Reset during OPEN_IN with the chamber loaded.
    for (int i = 0; i < 4; i++) exp_q.push_back(OOut);
    for (int i = 0; i < 5; i++) exp_q.push_back(OPress);
    for (int i = 0; i < 2; i++) exp_q.push_back(OIn);
    exp_q.push_back(OIdle);
    exp_q.push_back(OIdle);
    req_outer = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_open[%0d]: got %b required %b", i, obs, e);
      end
      if (i == 0) begin
        req_outer = 1'b0;
        pass_done = 1'b1;
      end
      if (i == 8) pass_done = 1'b0;
    end
    rst = 1'b1;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_open_async: got %b required %b", obs, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_open_idle: got %b required %b", obs, e);
    end

    // Fresh entry: a cleared load bit means pass_done leads on to PRESS, not back to idle.
    for (int i = 0; i < 4; i++) exp_q.push_back(OOut);
    exp_q.push_back(OPress);
    req_outer = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL restart[%0d]: got %b required %b", i, obs, e);
      end
      if (i == 0) begin
        req_outer = 1'b0;
        pass_done = 1'b1;
      end
    end
    pass_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_outer_transfer();
    test_same_side();
    test_inner_empty();
    test_timeout();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
